// File: rtl/tod_pkg.sv
// Shared types and limits for the time-of-day counter: field widths, field
// maxima, the packed time struct and the load range check.
package tod_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MS_W   = 6;

  localparam logic [MS_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MS_W-1:0] MIN_MAX = 6'd59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MS_W-1:0]   minute;
    logic [MS_W-1:0]   second;
  } tod_time_t;

  function automatic logic in_range(input tod_time_t t, input int unsigned hours_per_day);
    return (32'(t.hour) < hours_per_day) && (t.minute <= MIN_MAX) && (t.second <= SEC_MAX);
  endfunction

endpackage

// File: rtl/tod_bin2bcd2.sv
// Combinational two-digit converter: 6-bit binary (0..59 in normal use) to
// {tens,ones} BCD for the seven-segment decoders.
module bin2bcd2 (
  input  logic [5:0] bin,
  output logic [7:0] bcd
);

  logic [2:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens = 3'd0;
    if      (bin >= 6'd60) tens = 3'd6;
    else if (bin >= 6'd50) tens = 3'd5;
    else if (bin >= 6'd40) tens = 3'd4;
    else if (bin >= 6'd30) tens = 3'd3;
    else if (bin >= 6'd20) tens = 3'd2;
    else if (bin >= 6'd10) tens = 3'd1;
    ones = 4'(bin - (6'(tens) * 6'd10));
    bcd  = {1'b0, tens, ones};
  end

endmodule

// File: rtl/tod_counter.sv
// Time-of-day counter: prescaled seconds tick, run/stop, validated loading,
// sticky alarm and 12h/24h display conversion to BCD.
module tod_counter
  import tod_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 100000000,
  parameter int unsigned HOURS_PER_DAY = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              set_valid,
  input  logic [HOUR_W-1:0] set_h,
  input  logic [MS_W-1:0]   set_m,
  input  logic [MS_W-1:0]   set_s,
  output logic              set_err,
  input  logic              alarm_en,
  input  logic [HOUR_W-1:0] alarm_h,
  input  logic [MS_W-1:0]   alarm_m,
  input  logic [MS_W-1:0]   alarm_s,
  input  logic              alarm_ack,
  output logic              alarm_hit,
  output logic              alarm_flag,
  input  logic              mode_12h,
  output logic              tick,
  output logic              day_wrap,
  output logic [HOUR_W-1:0] hour,
  output logic [MS_W-1:0]   minute,
  output logic [MS_W-1:0]   second,
  output logic [7:0]        hr_bcd,
  output logic [7:0]        min_bcd,
  output logic [7:0]        sec_bcd,
  output logic              pm
);

  localparam int unsigned       PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [HOUR_W-1:0] HOUR_MAX  = HOUR_W'(HOURS_PER_DAY - 1);

  logic [PW-1:0] presc_q, presc_d;
  tod_time_t     time_q, time_d;
  logic          tick_q, tick_d;
  logic          day_wrap_q, day_wrap_d;
  logic          set_err_q, set_err_d;
  logic          alarm_hit_q, alarm_hit_d;
  logic          alarm_flag_q, alarm_flag_d;

  tod_time_t set_t, alarm_t, inc_t;
  logic      inc_wrap;
  logic      terminal;

  // Next time-of-day one second ahead, with the day wrap carry.
  always_comb begin
    inc_t    = time_q;
    inc_wrap = 1'b0;
    if (time_q.second == SEC_MAX) begin
      inc_t.second = '0;
      if (time_q.minute == MIN_MAX) begin
        inc_t.minute = '0;
        if (time_q.hour == HOUR_MAX) begin
          inc_t.hour = '0;
          inc_wrap   = 1'b1;
        end else begin
          inc_t.hour = time_q.hour + 1'b1;
        end
      end else begin
        inc_t.minute = time_q.minute + 1'b1;
      end
    end else begin
      inc_t.second = time_q.second + 1'b1;
    end
  end

  always_comb begin
    set_t    = '{hour: set_h, minute: set_m, second: set_s};
    alarm_t  = '{hour: alarm_h, minute: alarm_m, second: alarm_s};
    terminal = run && (presc_q == PRESC_MAX);

    presc_d     = presc_q;
    time_d      = time_q;
    tick_d      = 1'b0;
    day_wrap_d  = 1'b0;
    set_err_d   = 1'b0;
    alarm_hit_d = 1'b0;

    // Any load request owns the cycle: a rejected one freezes time and phase,
    // an accepted one restarts the second from a clean prescaler phase.
    if (set_valid) begin
      if (in_range(set_t, HOURS_PER_DAY)) begin
        time_d  = set_t;
        presc_d = '0;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (run) begin
      if (terminal) begin
        presc_d    = '0;
        time_d     = inc_t;
        tick_d     = 1'b1;
        day_wrap_d = inc_wrap;
        // inc_t is always in range, so an out-of-range alarm can never match.
        alarm_hit_d = alarm_en && (inc_t == alarm_t);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (alarm_hit_d)    alarm_flag_d = 1'b1;
    else if (alarm_ack) alarm_flag_d = 1'b0;
    else                alarm_flag_d = alarm_flag_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      time_q       <= '0;
      tick_q       <= 1'b0;
      day_wrap_q   <= 1'b0;
      set_err_q    <= 1'b0;
      alarm_hit_q  <= 1'b0;
      alarm_flag_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      time_q       <= time_d;
      tick_q       <= tick_d;
      day_wrap_q   <= day_wrap_d;
      set_err_q    <= set_err_d;
      alarm_hit_q  <= alarm_hit_d;
      alarm_flag_q <= alarm_flag_d;
    end
  end

  assign tick       = tick_q;
  assign day_wrap   = day_wrap_q;
  assign set_err    = set_err_q;
  assign alarm_hit  = alarm_hit_q;
  assign alarm_flag = alarm_flag_q;
  assign hour       = time_q.hour;
  assign minute     = time_q.minute;
  assign second     = time_q.second;

  logic [MS_W-1:0] hr_disp;

  always_comb begin
    hr_disp = MS_W'(time_q.hour);
    pm      = 1'b0;
    if (mode_12h) begin
      pm = (time_q.hour >= 5'd12);
      if (time_q.hour == '0)        hr_disp = 6'd12;
      else if (time_q.hour > 5'd12) hr_disp = MS_W'(time_q.hour - 5'd12);
    end
  end

  bin2bcd2 u_hr_bcd  (.bin(hr_disp),       .bcd(hr_bcd));
  bin2bcd2 u_min_bcd (.bin(time_q.minute), .bcd(min_bcd));
  bin2bcd2 u_sec_bcd (.bin(time_q.second), .bcd(sec_bcd));

endmodule

// File: tb/tb_tod_counter.sv
// Bench for tod_counter: directed steps followed by random traffic, checked
// against a seconds-of-day reference model.
module tb_tod_counter;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned HPD      = 24;
  localparam int          DAY_SECS = HPD * 3600;

  logic       clk = 1'b0;
  logic       reset, run, set_valid, alarm_en, alarm_ack, mode_12h;
  logic [4:0] set_h, alarm_h;
  logic [5:0] set_m, set_s, alarm_m, alarm_s;
  logic       set_err, alarm_hit, alarm_flag, tick, day_wrap, pm;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic [7:0] hr_bcd, min_bcd, sec_bcd;

  int errors = 0;
  int checks = 0;

  // Model state: time as seconds since midnight plus prescaler phase.
  int m_secs, m_phase;
  bit m_flag;

  // Expected registered state: {tick, day_wrap, set_err, alarm_hit, alarm_flag, secs[16:0]}
  logic [21:0] exp_q[$];

  tod_counter #(.TICK_DIV(TICK_DIV), .HOURS_PER_DAY(HPD)) dut (
    .clk(clk), .reset(reset), .run(run),
    .set_valid(set_valid), .set_h(set_h), .set_m(set_m), .set_s(set_s), .set_err(set_err),
    .alarm_en(alarm_en), .alarm_h(alarm_h), .alarm_m(alarm_m), .alarm_s(alarm_s),
    .alarm_ack(alarm_ack), .alarm_hit(alarm_hit), .alarm_flag(alarm_flag),
    .mode_12h(mode_12h), .tick(tick), .day_wrap(day_wrap),
    .hour(hour), .minute(minute), .second(second),
    .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .pm(pm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Predict the registered state after the coming edge from the current inputs.
  task automatic model_step();
    bit t, w, e, h;
    int alarm_secs;
    t = 0; w = 0; e = 0; h = 0;
    if (reset) begin
      m_secs = 0; m_phase = 0; m_flag = 0;
    end else begin
      if (set_valid) begin
        if (int'(set_h) < HPD && int'(set_m) < 60 && int'(set_s) < 60) begin
          m_secs  = int'(set_h) * 3600 + int'(set_m) * 60 + int'(set_s);
          m_phase = 0;
        end else begin
          e = 1;
        end
      end else if (run) begin
        m_phase++;
        if (m_phase == TICK_DIV) begin
          m_phase = 0;
          m_secs  = (m_secs + 1) % DAY_SECS;
          t = 1;
          w = (m_secs == 0);
          alarm_secs = int'(alarm_h) * 3600 + int'(alarm_m) * 60 + int'(alarm_s);
          h = alarm_en && int'(alarm_h) < HPD && int'(alarm_m) < 60 && int'(alarm_s) < 60
              && alarm_secs == m_secs;
        end
      end
      if (h)              m_flag = 1;
      else if (alarm_ack) m_flag = 0;
    end
    exp_q.push_back({t, w, e, h, m_flag, 17'(m_secs)});
  endtask

  task automatic check_all();
    logic [21:0] e;
    int secs, h, m, s, hd;
    e    = exp_q.pop_front();
    secs = int'(e[16:0]);
    h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
    hd = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    chk("tick",       32'(tick),       32'(e[21]));
    chk("day_wrap",   32'(day_wrap),   32'(e[20]));
    chk("set_err",    32'(set_err),    32'(e[19]));
    chk("alarm_hit",  32'(alarm_hit),  32'(e[18]));
    chk("alarm_flag", 32'(alarm_flag), 32'(e[17]));
    chk("hour",       32'(hour),       32'(h));
    chk("minute",     32'(minute),     32'(m));
    chk("second",     32'(second),     32'(s));
    chk("hr_bcd",     32'(hr_bcd),     32'(to_bcd(hd)));
    chk("min_bcd",    32'(min_bcd),    32'(to_bcd(m)));
    chk("sec_bcd",    32'(sec_bcd),    32'(to_bcd(s)));
    chk("pm",         32'(pm),         32'(mode_12h && h >= 12));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int h, input int m, input int s);
    set_valid = 1'b1;
    set_h = 5'(h); set_m = 6'(m); set_s = 6'(s);
    step();
    set_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; set_valid = 1'b0; alarm_en = 1'b0; alarm_ack = 1'b0;
    mode_12h = 1'b0; set_h = '0; set_m = '0; set_s = '0;
    alarm_h = '0; alarm_m = '0; alarm_s = '0;
    m_secs = 0; m_phase = 0; m_flag = 0;
    #2;

    // Reset with run held, then release: first tick four cycles later.
    steps(5);
    reset = 1'b0;
    steps(3);
    chk("no_tick_before_div", 32'(tick), 32'd0);
    step();
    chk("first_tick", 32'(tick), 32'd1);
    chk("sec_bcd_first", 32'(sec_bcd), 32'h01);
    steps(8);

    // Day wrap from 23:59:59.
    load(23, 59, 59);
    steps(4);
    chk("wrap_tick", 32'(tick), 32'd1);
    chk("wrap_day_wrap", 32'(day_wrap), 32'd1);
    step();
    chk("wrap_pulse_end", 32'(day_wrap), 32'd0);

    // Rejected loads leave time untouched.
    load(24, 0, 0);
    chk("err_hour", 32'(set_err), 32'd1);
    load(10, 60, 0);
    chk("err_minute", 32'(set_err), 32'd1);
    step();

    // Alarm at 00:00:02, then ack, then ack coinciding with a fresh hit.
    alarm_en = 1'b1; alarm_h = 5'd0; alarm_m = 6'd0; alarm_s = 6'd2;
    load(0, 0, 0);
    steps(12);
    chk("flag_sticky", 32'(alarm_flag), 32'd1);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("flag_cleared", 32'(alarm_flag), 32'd0);
    load(0, 0, 1);
    steps(3);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("ack_hit_hit", 32'(alarm_hit), 32'd1);
    chk("ack_hit_flag", 32'(alarm_flag), 32'd1);
    alarm_en = 1'b0;

    // 12h display mapping.
    run = 1'b0; mode_12h = 1'b1;
    load(0, 15, 0);
    chk("h12_midnight", 32'(hr_bcd), 32'h12);
    load(13, 5, 0);
    chk("h12_pm_bcd", 32'(hr_bcd), 32'h01);
    chk("h12_pm", 32'(pm), 32'd1);
    chk("h12_bin", 32'(hour), 32'd13);
    mode_12h = 1'b0;

    // Load at terminal count, then freeze mid-count and resume.
    run = 1'b1;
    load(1, 2, 3);
    steps(3);
    load(5, 6, 7);
    chk("load_beats_tick", 32'(tick), 32'd0);
    steps(2);
    run = 1'b0;
    steps(10);
    run = 1'b1;
    steps(1);
    chk("resume_pending", 32'(tick), 32'd0);
    step();
    chk("resume_tick", 32'(second), 32'd8);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      mode_12h  = 1'($urandom_range(0, 1));
      alarm_ack = ($urandom_range(0, 7) == 0);
      alarm_en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        alarm_h = 5'(m_secs / 3600);
        alarm_m = 6'((m_secs / 60) % 60);
        alarm_s = 6'($urandom_range(0, 63));
      end
      set_valid = ($urandom_range(0, 19) == 0);
      set_h = 5'($urandom_range(0, 26));
      set_m = 6'($urandom_range(0, 61));
      set_s = 6'($urandom_range(55, 63));
      step();
    end
    set_valid = 1'b0;
    alarm_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tod_counter.md
Name: tod_counter

Overview:
Parametrised time-of-day counter (hours/minutes/seconds) for the display path. It is the next generation of the basic digital clock and adds the following:
- an internal prescaler, so the seconds tick is derived from the system clock;
- run/stop control;
- validated time loading;
- an alarm comparator with a sticky flag;
- runtime 12h/24h display mode.

Outputs are binary time plus two-digit BCD per field, which feed the seven-segment decoders.

Parameters:
TICK_DIV, 100000000, system clock cycles per second tick; must be >= 1.
HOURS_PER_DAY, 24, hour counter modulus, 2..32; the hour field is 5 bits.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  1 = prescaler and time advance; 0 = frozen
set_valid  in  1  load request, one cycle
set_h  in  5  hour to load, binary
set_m  in  6  minute to load
set_s  in  6  second to load
set_err  out  1  one-cycle pulse: load rejected, value out of range
alarm_en  in  1  alarm compare enable
alarm_h  in  5  alarm hour
alarm_m  in  6  alarm minute
alarm_s  in  6  alarm second
alarm_ack  in  1  clears alarm_flag
alarm_hit  out  1  one-cycle pulse on alarm match
alarm_flag  out  1  sticky alarm indication
mode_12h  in  1  display mode select
tick  out  1  one-cycle pulse, seconds advance
day_wrap  out  1  one-cycle pulse, hour wraps to 0
hour  out  5  binary hour, 0..HOURS_PER_DAY-1
minute  out  6  binary minute 0..59
second  out  6  binary second 0..59
hr_bcd  out  8  display hour, {tens,ones}; 12h-adjusted when mode_12h=1
min_bcd  out  8  {tens,ones}
sec_bcd  out  8  {tens,ones}
pm  out  1  1 when hour >= 12 and mode_12h=1, else 0

Behaviour:
- Reset is synchronous, active-high, and overrides everything. It clears:
  - prescaler, hour, minute, second to 0;
  - tick, day_wrap, set_err, alarm_hit, alarm_flag to 0.
  - BCD outputs then read 00/00/00, or 12/00/00 if mode_12h=1; pm=0.
- Prescaler: counter 0..TICK_DIV-1, incrementing only while run=1.
  - At TICK_DIV-1 it wraps to 0, and tick asserts for the cycle after that edge.
  - With TICK_DIV=1, tick fires every run cycle.
  - run=0 holds the prescaler value; no reset of the phase.
- Time advance, on the edge where an internal tick is generated:
  - second increments; 59 -> 0 carries into minute.
  - minute 59 -> 0 carries into hour.
  - hour HOURS_PER_DAY-1 -> 0 pulses day_wrap in the same cycle as the tick pulse.
  - Outputs update one cycle after the prescaler terminal count.
- Load:
  - Valid load (set_h < HOURS_PER_DAY, set_m <= 59, set_s <= 59): time takes the set values at the next edge and the prescaler clears to 0.
  - Invalid load: time and prescaler are unchanged, and set_err pulses for one cycle.
  - Load beats a same-cycle tick. The tick is dropped; no tick, day_wrap or alarm_hit.
- Alarm:
  - Evaluated only on advance. If alarm_en=1 and the new time equals alarm_h:m:s, alarm_hit pulses in the same cycle the new time appears, and alarm_flag sets.
  - A load never triggers the alarm.
  - alarm_ack clears alarm_flag. Simultaneous ack and hit leaves the flag at 1 (set wins).
  - Out-of-range alarm values simply never match.
- Display:
  - hour, minute, second: registered binary.
  - BCD outputs: combinational from the registered values.
  - 12h mapping: hour 0 -> 12, 1..12 -> same, 13..23 -> hour-12; pm = (hour >= 12).
  - mode_12h affects display only, never counting.
- Widths: prescaler width is clog2(TICK_DIV), minimum 1. All comparisons are unsigned; no overflow is reachable given the range checks.

Decomposition:
- Package tod_pkg holds:
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_W=5, MS_W=6;
  - typedef tod_time_t, a packed struct {hour, minute, second};
  - function in_range(tod_time_t, hours_per_day).
- One sub-module: bin2bcd2, combinational 6-bit binary 0..59 -> {tens,ones}. It is instantiated three times, on the hour after 12h mapping.

Test Plan:
- Reset with TICK_DIV=4, run=1 held for 5 cycles, then released -> 00:00:00, flags 0; first tick 4 cycles later, then every 4 cycles; sec_bcd=8'h01 after the first tick.
- Load 23:59:59, then one tick -> 00:00:00; day_wrap and tick both high for exactly one cycle.
- Load 24:00:00 (HOURS_PER_DAY=24) -> set_err for 1 cycle, time unchanged. Load 10:60:00 -> also rejected.
- Alarm 00:00:02 enabled from 00:00:00 -> alarm_hit on the 2nd tick only; flag stays high until alarm_ack; ack in the same cycle as a new hit leaves flag=1.
- mode_12h=1: load 00:15:00 -> hr_bcd=8'h12, pm=0; load 13:05:00 -> hr_bcd=8'h01, pm=1; binary hour=13 unchanged.
- set_valid coincident with the prescaler terminal count, and run=0 mid-count -> load wins with no tick; frozen time holds across 10 cycles; resuming completes the remaining prescaler count.
